// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 timing constants and lock-state type shared with the generator
package vga_timing_pkg;
    localparam int unsigned H_ACTIVE     = 640;
    localparam int unsigned H_SYNC_START = 656;
    localparam int unsigned H_SYNC_END   = 752;
    localparam int unsigned H_TOTAL      = 800;
    localparam int unsigned V_ACTIVE     = 480;
    localparam int unsigned V_SYNC_START = 490;
    localparam int unsigned V_SYNC_END   = 492;
    localparam int unsigned V_TOTAL      = 525;
    localparam int unsigned LOCK_FRAMES  = 2;

    typedef enum logic [1:0] {
        SEARCH,
        CHECK,
        LOCKED
    } lock_state_e;
endpackage

// File: rtl/vga_axis_tracker.sv
// rtl/vga_axis_tracker.sv - one timing axis: wrapping position counter resynced by its active-low sync
module vga_axis_tracker #(
    parameter logic [9:0] TOTAL      = 10'(vga_timing_pkg::H_TOTAL),
    parameter logic [9:0] SYNC_START = 10'(vga_timing_pkg::H_SYNC_START),
    parameter logic [9:0] SYNC_END   = 10'(vga_timing_pkg::H_SYNC_END)
) (
    input  logic       clk,
    input  logic       i_rst,
    input  logic       i_step,
    input  logic       i_adv,
    input  logic       i_zero,
    input  logic       i_align,
    input  logic       i_sync,
    output logic [9:0] o_cnt,
    output logic [9:0] o_pred,
    output logic [9:0] o_next,
    output logic       o_wrap,
    output logic       o_fall,
    output logic       o_err
);
    logic [9:0] r_cnt;
    logic       r_prev;
    logic       w_rise;

    assign o_wrap = i_adv && (r_cnt == TOTAL - 10'd1);
    assign o_pred = o_wrap ? 10'd0 : (i_adv ? r_cnt + 10'd1 : r_cnt);
    assign o_fall = r_prev && !i_sync;
    assign w_rise = !r_prev && i_sync;
    // An edge is good only where the free-running count already expects it; i_align adds the other axis.
    assign o_err  = (o_fall && ((o_pred != SYNC_START) || !i_align)) ||
                    (w_rise && ((o_pred != SYNC_END) || !i_align));
    assign o_next = i_zero ? 10'd0 : (o_fall ? SYNC_START : o_pred);
    assign o_cnt  = r_cnt;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt  <= 10'd0;
            r_prev <= 1'b1;
        end else if (i_step) begin
            r_cnt  <= o_next;
            r_prev <= i_sync;
        end
    end
endmodule

// File: rtl/vga_timing_recovery.sv
// rtl/vga_timing_recovery.sv - recovers x/y/blank and lock status from sampled hsync/vsync
module vga_timing_recovery #(
    parameter int unsigned H_ACTIVE     = vga_timing_pkg::H_ACTIVE,
    parameter int unsigned H_SYNC_START = vga_timing_pkg::H_SYNC_START,
    parameter int unsigned H_SYNC_END   = vga_timing_pkg::H_SYNC_END,
    parameter int unsigned H_TOTAL      = vga_timing_pkg::H_TOTAL,
    parameter int unsigned V_ACTIVE     = vga_timing_pkg::V_ACTIVE,
    parameter int unsigned V_SYNC_START = vga_timing_pkg::V_SYNC_START,
    parameter int unsigned V_SYNC_END   = vga_timing_pkg::V_SYNC_END,
    parameter int unsigned V_TOTAL      = vga_timing_pkg::V_TOTAL,
    parameter int unsigned LOCK_FRAMES  = vga_timing_pkg::LOCK_FRAMES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       blank,
    output logic       pix_valid,
    output logic       locked,
    output logic       h_err,
    output logic       v_err
);
    import vga_timing_pkg::*;

    localparam logic [9:0] L_H_ACTIVE = 10'(H_ACTIVE);
    localparam logic [9:0] L_V_ACTIVE = 10'(V_ACTIVE);
    localparam logic [2:0] L_LOCK     = 3'(LOCK_FRAMES);

    logic [9:0]  w_x_pred, w_x_next, w_y_next, w_y_pred_unused;
    logic        w_h_wrap, w_h_fall_unused, w_h_err;
    logic        w_v_wrap_unused, w_v_fall, w_v_err, w_err;
    lock_state_e r_state;
    logic [2:0]  r_count;
    logic        r_blank, r_pix_valid, r_locked, r_h_err, r_v_err;

    // A vsync fall marks line start, so it also forces the horizontal count to zero.
    vga_axis_tracker #(
        .TOTAL(10'(H_TOTAL)), .SYNC_START(10'(H_SYNC_START)), .SYNC_END(10'(H_SYNC_END))
    ) u_h_axis (
        .clk(clk), .i_rst(reset), .i_step(pix_en), .i_adv(1'b1), .i_zero(w_v_fall),
        .i_align(1'b1), .i_sync(hsync_in), .o_cnt(x), .o_pred(w_x_pred), .o_next(w_x_next),
        .o_wrap(w_h_wrap), .o_fall(w_h_fall_unused), .o_err(w_h_err)
    );

    vga_axis_tracker #(
        .TOTAL(10'(V_TOTAL)), .SYNC_START(10'(V_SYNC_START)), .SYNC_END(10'(V_SYNC_END))
    ) u_v_axis (
        .clk(clk), .i_rst(reset), .i_step(pix_en), .i_adv(w_h_wrap), .i_zero(1'b0),
        .i_align(w_x_pred == 10'd0), .i_sync(vsync_in), .o_cnt(y), .o_pred(w_y_pred_unused),
        .o_next(w_y_next), .o_wrap(w_v_wrap_unused), .o_fall(w_v_fall), .o_err(w_v_err)
    );

    assign w_err = w_h_err || w_v_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= SEARCH;
            r_count     <= 3'd0;
            r_blank     <= 1'b0;
            r_pix_valid <= 1'b0;
            r_locked    <= 1'b0;
            r_h_err     <= 1'b0;
            r_v_err     <= 1'b0;
        end else begin
            r_pix_valid <= pix_en;
            r_h_err     <= pix_en && w_h_err;
            r_v_err     <= pix_en && w_v_err;
            if (pix_en) begin
                r_blank <= (w_x_next >= L_H_ACTIVE) || (w_y_next >= L_V_ACTIVE);
                case (r_state)
                    SEARCH: begin
                        // A vsync fall that is itself misplaced does not start the qualification.
                        if (w_v_fall && !w_err) begin
                            r_state <= CHECK;
                            r_count <= 3'd0;
                        end
                    end
                    CHECK: begin
                        if (w_err) begin
                            r_state <= SEARCH;
                            r_count <= 3'd0;
                        end else if (w_v_fall) begin
                            r_count <= r_count + 3'd1;
                            if (r_count + 3'd1 == L_LOCK) begin
                                r_state  <= LOCKED;
                                r_locked <= 1'b1;
                            end
                        end
                    end
                    LOCKED: begin
                        if (w_err) begin
                            r_state  <= SEARCH;
                            r_count  <= 3'd0;
                            r_locked <= 1'b0;
                        end
                    end
                    default: begin
                        r_state  <= SEARCH;
                        r_count  <= 3'd0;
                        r_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign blank     = r_blank;
    assign pix_valid = r_pix_valid;
    assign locked    = r_locked;
    assign h_err     = r_h_err;
    assign v_err     = r_v_err;
endmodule

// File: tb/tb_vga_timing_recovery.sv
// tb/tb_vga_timing_recovery.sv - randomized loopback and fault-injection bench with queued expectations
module tb_vga_timing_recovery;
    localparam int HA = 16, HSS = 18, HSE = 21, HT = 24;
    localparam int VA = 10, VSS = 11, VSE = 12, VT = 14;
    localparam int LF = 2;
    localparam int BOUND = 4000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pix_en = 1'b0;
    logic       hsync_in = 1'b1;
    logic       vsync_in = 1'b1;
    logic [9:0] x, y;
    logic       blank, pix_valid, locked, h_err, v_err;

    vga_timing_recovery #(
        .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_END(HSE), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_END(VSE), .V_TOTAL(VT),
        .LOCK_FRAMES(LF)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .x(x), .y(y), .blank(blank), .pix_valid(pix_valid), .locked(locked),
        .h_err(h_err), .v_err(v_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        bit blank;
        bit h_err;
        bit v_err;
        bit locked;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp;
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_err_pulses = 0;

    int mx, my, mstate, mcount;
    bit mphs, mpvs;
    int gx = 1, gy = 0, early_line = -1, n_gen_falls = 0;
    bit skip_pending = 1'b0, gpvs = 1'b1;

    function automatic void chk(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endfunction

    function automatic void model_reset();
        mx = 0; my = 0; mphs = 1'b1; mpvs = 1'b1; mstate = 0; mcount = 0;
        last_exp = '{0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    endfunction

    // Position arithmetic straight from the timing rules; lock state 0=search 1=check 2=locked.
    function automatic exp_t model_step(input bit hs, input bit vs);
        exp_t e;
        int px, py;
        bit hf, hr, vf, vr, herr, verr;
        px = (mx + 1) % HT;
        py = (mx == HT - 1) ? (my + 1) % VT : my;
        hf = mphs && !hs;
        hr = !mphs && hs;
        vf = mpvs && !vs;
        vr = !mpvs && vs;
        herr = (hf && px != HSS) || (hr && px != HSE);
        verr = ((vf || vr) && px != 0) || (vf && py != VSS) || (vr && py != VSE);
        mx = vf ? 0 : (hf ? HSS : px);
        my = vf ? VSS : py;
        mphs = hs;
        mpvs = vs;
        if (herr || verr) begin
            mstate = 0;
            mcount = 0;
        end else if (vf) begin
            if (mstate == 0) begin
                mstate = 1;
                mcount = 0;
            end else if (mstate == 1) begin
                mcount++;
                if (mcount == LF) mstate = 2;
            end
        end
        e.x = mx;
        e.y = my;
        e.blank = (mx >= HA) || (my >= VA);
        e.h_err = herr;
        e.v_err = verr;
        e.locked = (mstate == 2);
        return e;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (h_err || v_err) n_err_pulses++;
            if (pix_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pix_valid", exp_q.size(), 1);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("x", int'(x), mon_e.x);
                    chk("y", int'(y), mon_e.y);
                    chk("blank", int'(blank), int'(mon_e.blank));
                    chk("h_err", int'(h_err), int'(mon_e.h_err));
                    chk("v_err", int'(v_err), int'(mon_e.v_err));
                    chk("locked", int'(locked), int'(mon_e.locked));
                    last_exp = mon_e;
                end
            end else begin
                chk("idle_x_hold", int'(x), last_exp.x);
                chk("idle_y_hold", int'(y), last_exp.y);
                chk("idle_locked", int'(locked), int'(last_exp.locked));
                chk("idle_h_err", int'(h_err), 0);
                chk("idle_v_err", int'(v_err), 0);
            end
        end
    end

    task automatic strobe(input bit hs, input bit vs);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        pix_en = 1'b1;
        hsync_in = hs;
        vsync_in = vs;
        exp_q.push_back(model_step(hs, vs));
        @(negedge clk);
        pix_en = 1'b0;
    endtask

    task automatic gen_pix();
        bit hs, vs;
        hs = !(gx >= HSS && gx < HSE);
        if (gy == early_line && gx >= HSS - 4 && gx < HSE) hs = 1'b0;
        vs = !(gy >= VSS && gy < VSE);
        if (gpvs && !vs) n_gen_falls++;
        gpvs = vs;
        strobe(hs, vs);
        gx++;
        if (gx == HT) begin
            gx = 0;
            if (gy == early_line) early_line = -1;
            if (skip_pending && gy == VSS - 2) begin
                gy = VSS;
                skip_pending = 1'b0;
            end else begin
                gy = (gy + 1) % VT;
            end
        end
    endtask

    task automatic run_to(input int tx, input int ty);
        int n;
        n = 0;
        while (!(gx == tx && gy == ty) && n < BOUND) begin
            gen_pix();
            n++;
        end
        chk("run_to_reached", int'(gx == tx && gy == ty), 1);
    endtask

    task automatic run_falls(input int k);
        int target, n;
        target = n_gen_falls + k;
        n = 0;
        while (n_gen_falls < target && n < BOUND * 2) begin
            gen_pix();
            n++;
        end
        chk("run_falls_reached", n_gen_falls, target);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_x", int'(x), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_blank", int'(blank), 0);
        chk("rst_pix_valid", int'(pix_valid), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_h_err", int'(h_err), 0);
        chk("rst_v_err", int'(v_err), 0);
        reset = 1'b0;

        run_falls(2);
        chk("lock_not_at_fall2", int'(locked), 0);
        run_falls(1);
        chk("lock_at_fall3", int'(locked), 1);
        chk("loopback_no_err_pulses", n_err_pulses, 0);

        early_line = 2;
        run_to(HSS - 4, 2);
        gen_pix();
        chk("early_hs_h_err", int'(h_err), 1);
        chk("early_hs_unlock", int'(locked), 0);
        chk("early_hs_x_forced", int'(x), HSS);
        run_falls(3);
        chk("relock_after_hs_glitch", int'(locked), 1);

        skip_pending = 1'b1;
        run_falls(1);
        chk("early_vs_v_err", int'(v_err), 1);
        chk("early_vs_y_forced", int'(y), VSS);
        chk("early_vs_unlock", int'(locked), 0);
        run_falls(2);
        chk("no_relock_after_2", int'(locked), 0);
        run_falls(1);
        chk("relock_after_3", int'(locked), 1);

        run_to(8, 3);
        gen_pix();
        repeat (100) @(negedge clk);
        chk("hold_x", int'(x), 8);
        chk("hold_pix_valid", int'(pix_valid), 0);

        run_to(HA - 1, 0);
        gen_pix();
        chk("blank_x_last_active", int'(blank), 0);
        gen_pix();
        chk("blank_x_first_inactive", int'(blank), 1);
        run_to(0, VA);
        gen_pix();
        chk("blank_y_first_inactive", int'(blank), 1);
        run_to(HT - 1, VT - 1);
        gen_pix();
        gen_pix();
        chk("wrap_x", int'(x), 0);
        chk("wrap_y", int'(y), 0);
        chk("blank_after_wrap", int'(blank), 0);

        run_to(20, 5);
        gen_pix();
        chk("pre_reset_locked", int'(locked), 1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_x", int'(x), 0);
        chk("async_rst_y", int'(y), 0);
        chk("async_rst_locked", int'(locked), 0);
        chk("async_rst_blank", int'(blank), 0);
        exp_q.delete();
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        run_to(HSS, 6);
        gen_pix();
        chk("post_reset_hs_fall_x", int'(x), HSS);
        run_falls(3);
        chk("post_reset_not_locked", int'(locked), 0);
        run_falls(1);
        chk("post_reset_relock", int'(locked), 1);

        for (int i = 0; i < 150; i++) strobe(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        run_falls(5);
        chk("relock_after_noise", int'(locked), 1);

        repeat (4) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
